dead_time_gen_mc: RTL and testbench

//  Multi-channel complementary-pair dead-time generator; successor to the single-pair dead timer.
//  Per channel: one PWM reference in, high-side/low-side gate drives out.

---
 rtl/dead_time_pkg.sv | 15 +
 rtl/dt_channel.sv | 127 ++++++++++++
 rtl/dead_time_gen_mc.sv | 67 ++++++
 tb/tb_dead_time_gen_mc.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dead_time_pkg.sv
// Shared types and defaults for the multi-channel dead-time generator.
package dead_time_pkg;

   localparam int DT_WIDTH_DEF = 16;
   localparam int NUM_CH_DEF   = 4;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_DT_HI,
      ST_HI,
      ST_DT_LO,
      ST_LO
   } dt_state_e;

endpackage

// File: rtl/dt_channel.sv
// One complementary pair: state machine, dead-time down-counter and
// registered gate-drive decode.
module dt_channel
   import dead_time_pkg::*;
#(
   parameter int DT_WIDTH = DT_WIDTH_DEF
) (
   input  logic                MClk,
   input  logic                Rst,
   input  logic                Kill,
   input  logic                PwmIn,
   input  logic [DT_WIDTH-1:0] DtRise,
   input  logic [DT_WIDTH-1:0] DtFall,
   output logic                SHi,
   output logic                SLo,
   output logic                DtBusy
);

   localparam logic [DT_WIDTH-1:0] ONE = DT_WIDTH'(1);

   dt_state_e           r_state;
   logic [DT_WIDTH-1:0] r_cnt;
   logic                r_from_off;
   logic                r_shi;
   logic                r_slo;
   logic                r_busy;

   dt_state_e           w_nxt;
   logic [DT_WIDTH-1:0] w_cnt;
   logic                w_from_off;
   logic                w_rise_zero;
   logic                w_fall_zero;

   assign w_rise_zero = (DtRise == '0);
   assign w_fall_zero = (DtFall == '0);

   always_comb begin
      w_nxt      = r_state;
      w_cnt      = r_cnt;
      w_from_off = r_from_off;
      if (Kill) begin
         w_nxt = ST_OFF;
      end else begin
         unique case (r_state)
            ST_OFF: begin
               w_from_off = 1'b1;
               if (PwmIn) begin
                  w_cnt = DtRise;
                  w_nxt = w_rise_zero ? ST_HI : ST_DT_HI;
               end else begin
                  w_cnt = DtFall;
                  w_nxt = w_fall_zero ? ST_LO : ST_DT_LO;
               end
            end
            ST_HI: begin
               if (!PwmIn) begin
                  w_from_off = 1'b0;
                  w_cnt      = DtFall;
                  w_nxt      = w_fall_zero ? ST_LO : ST_DT_LO;
               end
            end
            ST_LO: begin
               if (PwmIn) begin
                  w_from_off = 1'b0;
                  w_cnt      = DtRise;
                  w_nxt      = w_rise_zero ? ST_HI : ST_DT_HI;
               end
            end
            ST_DT_HI: begin
               // Abort: after OFF neither side was on, so retarget with a full load
               if (!PwmIn) begin
                  if (r_from_off) begin
                     w_cnt = DtFall;
                     w_nxt = w_fall_zero ? ST_LO : ST_DT_LO;
                  end else begin
                     w_nxt = ST_LO;
                  end
               end else if (r_cnt <= ONE) begin
                  w_cnt = '0;
                  w_nxt = ST_HI;
               end else begin
                  w_cnt = r_cnt - ONE;
               end
            end
            ST_DT_LO: begin
               if (PwmIn) begin
                  if (r_from_off) begin
                     w_cnt = DtRise;
                     w_nxt = w_rise_zero ? ST_HI : ST_DT_HI;
                  end else begin
                     w_nxt = ST_HI;
                  end
               end else if (r_cnt <= ONE) begin
                  w_cnt = '0;
                  w_nxt = ST_LO;
               end else begin
                  w_cnt = r_cnt - ONE;
               end
            end
            default: w_nxt = ST_OFF;
         endcase
      end
   end

   always_ff @(posedge MClk) begin
      if (Rst) begin
         r_state    <= ST_OFF;
         r_cnt      <= '0;
         r_from_off <= 1'b0;
         r_shi      <= 1'b0;
         r_slo      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_nxt;
         r_cnt      <= w_cnt;
         r_from_off <= w_from_off;
         r_shi      <= (w_nxt == ST_HI);
         r_slo      <= (w_nxt == ST_LO);
         r_busy     <= (w_nxt == ST_DT_HI) || (w_nxt == ST_DT_LO);
      end
   end

   assign SHi    = r_shi;
   assign SLo    = r_slo;
   assign DtBusy = r_busy;

endmodule

// File: rtl/dead_time_gen_mc.sv
// Multi-channel dead-time generator: fault handling and kill fan-out.
// Define DT_FAULT_LATCH_EN to hold FaultAct until an explicit FaultClr.
module dead_time_gen_mc
   import dead_time_pkg::*;
#(
   parameter int NUM_CH   = NUM_CH_DEF,
   parameter int DT_WIDTH = DT_WIDTH_DEF
) (
   input  logic                             MClk,
   input  logic                             Rst,
   input  logic                             En,
   input  logic [NUM_CH-1:0]                PwmIn,
   input  logic [NUM_CH-1:0][DT_WIDTH-1:0]  DtRise,
   input  logic [NUM_CH-1:0][DT_WIDTH-1:0]  DtFall,
   input  logic                             Fault,
   input  logic                             FaultClr,
   output logic [NUM_CH-1:0]                SHi,
   output logic [NUM_CH-1:0]                SLo,
   output logic [NUM_CH-1:0]                DtBusy,
   output logic                             FaultAct
);

   logic r_fault_act;
   logic w_kill;

`ifdef DT_FAULT_LATCH_EN
   // A clear is only honoured once the fault source has gone away
   always_ff @(posedge MClk) begin
      if (Rst)
         r_fault_act <= 1'b0;
      else if (Fault)
         r_fault_act <= 1'b1;
      else if (FaultClr)
         r_fault_act <= 1'b0;
   end
`else
   logic w_unused_clr;
   assign w_unused_clr = FaultClr;

   always_ff @(posedge MClk) begin
      if (Rst)
         r_fault_act <= 1'b0;
      else
         r_fault_act <= Fault;
   end
`endif

   assign w_kill   = ~En | r_fault_act;
   assign FaultAct = r_fault_act;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      dt_channel #(
         .DT_WIDTH (DT_WIDTH)
      ) u_ch (
         .MClk   (MClk),
         .Rst    (Rst),
         .Kill   (w_kill),
         .PwmIn  (PwmIn[g]),
         .DtRise (DtRise[g]),
         .DtFall (DtFall[g]),
         .SHi    (SHi[g]),
         .SLo    (SLo[g]),
         .DtBusy (DtBusy[g])
      );
   end

endmodule

// File: tb/tb_dead_time_gen_mc.sv
// Bench for dead_time_gen_mc: directed vectors plus a per-cycle model compare.
module tb_dead_time_gen_mc;

   localparam int NCH = 4;
   localparam int DTW = 16;

   logic                     clk;
   logic                     Rst;
   logic                     En;
   logic [NCH-1:0]           PwmIn;
   logic [NCH-1:0][DTW-1:0]  DtRise;
   logic [NCH-1:0][DTW-1:0]  DtFall;
   logic                     Fault;
   logic                     FaultClr;
   logic [NCH-1:0]           SHi;
   logic [NCH-1:0]           SLo;
   logic [NCH-1:0]           DtBusy;
   logic                     FaultAct;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_sep = 0;

   dead_time_gen_mc #(
      .NUM_CH   (NCH),
      .DT_WIDTH (DTW)
   ) dut (
      .MClk     (clk),
      .Rst      (Rst),
      .En       (En),
      .PwmIn    (PwmIn),
      .DtRise   (DtRise),
      .DtFall   (DtFall),
      .Fault    (Fault),
      .FaultClr (FaultClr),
      .SHi      (SHi),
      .SLo      (SLo),
      .DtBusy   (DtBusy),
      .FaultAct (FaultAct)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Model: side on (0 none, 1 high, 2 low), side being approached during
   // dead time (0 none) and low-low cycles still owed.
   int m_on[NCH]  = '{default: 0};
   int m_tgt[NCH] = '{default: 0};
   int m_rem[NCH] = '{default: 0};
   bit m_off[NCH] = '{default: 0};
   bit m_fa = 0;

   task automatic m_start(int i, int s, bit from_off);
      int dt;
      dt = (s == 1) ? int'(DtRise[i]) : int'(DtFall[i]);
      m_off[i] = from_off;
      m_on[i]  = 0;
      if (dt == 0) begin
         m_on[i]  = s;
         m_tgt[i] = 0;
      end else begin
         m_tgt[i] = s;
         m_rem[i] = dt;
      end
   endtask

   task automatic m_step();
      bit kill;
      int want;
      kill = !En || m_fa;
      for (int i = 0; i < NCH; i++) begin
         want = PwmIn[i] ? 1 : 2;
         if (Rst || kill) begin
            m_on[i]  = 0;
            m_tgt[i] = 0;
         end else if (m_tgt[i] == 0 && m_on[i] == 0) begin
            m_start(i, want, 1'b1);
         end else if (m_tgt[i] == 0) begin
            if (m_on[i] != want) m_start(i, want, 1'b0);
         end else if (want != m_tgt[i]) begin
            if (m_off[i]) m_start(i, want, 1'b1);
            else begin
               m_on[i]  = want;
               m_tgt[i] = 0;
            end
         end else begin
            m_rem[i]--;
            if (m_rem[i] == 0) begin
               m_on[i]  = m_tgt[i];
               m_tgt[i] = 0;
            end
         end
      end
`ifdef DT_FAULT_LATCH_EN
      m_fa = !Rst && (Fault || (m_fa && !FaultClr));
`else
      m_fa = !Rst && Fault;
`endif
   endtask

   initial forever begin
      @(posedge clk);
      m_step();
   end

   // Per-channel bookkeeping for the dead-time separation assertion
   int ll[NCH]     = '{default: 0};
   int last_s[NCH] = '{default: 0};
   bit sawoff[NCH] = '{default: 1};

   task automatic compare_cycle();
      logic [NCH-1:0] eh, el, eb;
      int s, dt;
      for (int i = 0; i < NCH; i++) begin
         eh[i] = (m_on[i] == 1);
         el[i] = (m_on[i] == 2);
         eb[i] = (m_tgt[i] != 0);
      end
      check("cycle_outputs", 32'({SHi, SLo, DtBusy, FaultAct}),
            32'({eh, el, eb, m_fa}));
      check("no_overlap", 32'(SHi & SLo), 32'd0);
      for (int i = 0; i < NCH; i++) begin
         if (Rst) begin
            ll[i]     = 0;
            last_s[i] = 0;
            sawoff[i] = 1;
         end else if (!SHi[i] && !SLo[i]) begin
            ll[i]++;
            if (!DtBusy[i]) sawoff[i] = 1;
         end else begin
            s  = SHi[i] ? 1 : 2;
            dt = (s == 1) ? int'(DtRise[i]) : int'(DtFall[i]);
            if (chk_sep && (s != last_s[i] || sawoff[i]))
               check("dead_time_gap", 32'(ll[i] >= dt), 32'd1);
            ll[i]     = 0;
            last_s[i] = s;
            sawoff[i] = 0;
         end
      end
   endtask

   initial forever begin
      @(negedge clk);
      compare_cycle();
   end

   initial begin
      int nb;
      bit p;
      Rst      = 1'b1;
      En       = 1'b0;
      PwmIn    = '0;
      DtRise   = '0;
      DtFall   = '0;
      Fault    = 1'b0;
      FaultClr = 1'b0;
      cyc(2);
      check("reset_outputs", 32'({SHi, SLo, DtBusy, FaultAct}), 32'd0);

      // Release into rise dead time of 5 on ch0, fall dead time 2 elsewhere
      Rst    = 1'b0;
      En     = 1'b1;
      PwmIn  = 4'b0001;
      DtRise = {16'd2, 16'd2, 16'd2, 16'd5};
      DtFall = {16'd2, 16'd2, 16'd2, 16'd2};
      cyc(5);
      check("t1_still_dead", 32'({SHi[0], DtBusy[0]}), 32'b01);
      cyc(1);
      check("t1_hi_on", 32'({SHi, SLo}), 32'b0001_1110);

      // High to low with fall dead time 3
      DtFall[0] = 16'd3;
      PwmIn[0]  = 1'b0;
      nb = 0;
      for (int k = 1; k <= 4; k++) begin
         cyc(1);
         nb += int'(DtBusy[0]);
         if (k == 1) check("t2_hi_drop", 32'(SHi[0]), 32'd0);
         if (k == 3) check("t2_lo_wait", 32'(SLo[0]), 32'd0);
      end
      check("t2_lo_on", 32'(SLo[0]), 32'd1);
      check("t2_busy_len", 32'(nb), 32'd3);

      // Zero dead time: outputs follow PwmIn one cycle later
      DtRise[1] = 16'd0;
      DtFall[1] = 16'd0;
      p = 1'b1;
      for (int k = 0; k < 8; k++) begin
         PwmIn[1] = p;
         cyc(1);
         check("t3_follow", 32'({SHi[1], SLo[1]}), 32'({p, !p}));
         p = !p;
      end

      // Abort a long rise dead time: low side returns at once
      DtRise[2] = 16'd10;
      PwmIn[2]  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc(1);
         check("t4_in_dead", 32'({SHi[2], SLo[2], DtBusy[2]}), 32'b001);
      end
      PwmIn[2] = 1'b0;
      cyc(1);
      check("t4_abort", 32'({SHi[2], SLo[2], DtBusy[2]}), 32'b010);
      cyc(3);

      PwmIn = 4'b0101;
      cyc(15);
      check("t5_pre", 32'({SHi, SLo}), 32'b0101_1010);

      // One-cycle fault pulse
      Fault = 1'b1;
      cyc(1);
      check("t5_fa_set", 32'(FaultAct), 32'd1);
      check("t5_drive_held", 32'({SHi, SLo}), 32'b0101_1010);
      Fault = 1'b0;
      cyc(1);
      check("t5_killed", 32'({SHi, SLo, DtBusy}), 32'd0);
`ifdef DT_FAULT_LATCH_EN
      check("t5_fa_latched", 32'(FaultAct), 32'd1);
      cyc(3);
      check("t5_still_off", 32'({SHi, SLo, DtBusy, FaultAct}), 32'd1);
      FaultClr = 1'b1;
      cyc(1);
      FaultClr = 1'b0;
      check("t5_cleared", 32'({SHi, SLo, DtBusy, FaultAct}), 32'd0);
      cyc(1);
`else
      check("t5_fa_drop", 32'(FaultAct), 32'd0);
      cyc(1);
`endif
      check("t5_reenter", 32'({SHi, SLo, DtBusy}), 32'b0000_0010_1101);
      cyc(15);

      En = 1'b0;
      cyc(1);
      check("en_off", 32'({SHi, SLo, DtBusy}), 32'd0);
      En = 1'b1;
      cyc(12);

      // Random traffic in blocks, new dead times loaded under reset
      chk_sep = 1'b1;
      for (int b = 0; b < 5; b++) begin
         Rst = 1'b1;
         Fault = 1'b0;
         FaultClr = 1'b0;
         En = 1'b1;
         for (int i = 0; i < NCH; i++) begin
            DtRise[i] = 16'($urandom_range(6));
            DtFall[i] = 16'($urandom_range(6));
         end
         cyc(2);
         Rst = 1'b0;
         repeat (2000) begin
            for (int i = 0; i < NCH; i++)
               if ($urandom_range(7) == 0) PwmIn[i] = ~PwmIn[i];
            En       = ($urandom_range(63) != 0);
            Fault    = ($urandom_range(199) == 0);
            FaultClr = ($urandom_range(15) == 0);
            cyc(1);
         end
      end
      chk_sep = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
